// File: rtl/sla_pkg.sv
// Shared types and constants for the serial line arbiter.
package sla_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } sla_state_e;

  localparam int         N_REQ_C   = 3;
  localparam logic       LINE_IDLE = 1'b1;
  localparam logic [1:0] MODE_NONE = 2'd3;

endpackage

// File: rtl/sla_rr_pick.sv
// Rotating-priority picker: the search starts one past ptr and wraps, first eligible board wins.
module sla_rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any_valid
);

  always_comb begin
    int i;
    i         = 0;
    onehot    = '0;
    idx       = '0;
    any_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      i = (int'(ptr) + k) % N;
      if (!any_valid && elig[i]) begin
        any_valid = 1'b1;
        idx       = i[IW-1:0];
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_line_arbiter.sv
// Round-robin / manual owner of the shared serial line, with an idle-high guard between grants.
// Optional hold timeout and revoke blocking when SLA_TIMEOUT_EN is defined.
module serial_line_arbiter
  import sla_pkg::*;
#(
  parameter int N_REQ        = N_REQ_C,
  parameter int GUARD_CYCLES = 16,
  parameter int MAX_HOLD     = 4096
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] tx_in,
  input  logic             lock_mode,
  input  logic [1:0]       mode_sel,
  output logic [N_REQ-1:0] grant,
  output logic             out_final,
  output logic [N_REQ-1:0] LEDs,
  output logic             busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GW = $clog2(GUARD_CYCLES + 1);

  if (GUARD_CYCLES < 1 || MAX_HOLD < 1) begin : g_param_chk
    $error("GUARD_CYCLES and MAX_HOLD must be >= 1");
  end

  sla_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    win_q, win_d, ptr_q, ptr_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic             out_final_q, out_final_d;
  logic             busy_q, busy_d;

  logic [N_REQ-1:0] elig, pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_vld;
  logic             timeout;

`ifdef SLA_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0]    hold_q, hold_d;
  logic [N_REQ-1:0] revoked_q, revoked_d;
  assign timeout = (state_q == GRANT) && (hold_q == HW'(MAX_HOLD - 1));
`else
  assign timeout = 1'b0;
`endif

  // Manual mode narrows eligibility to mode_sel; MODE_NONE matches no board.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++)
      elig[i] = req[i] && (!lock_mode || (mode_sel == 2'(i)));
`ifdef SLA_TIMEOUT_EN
    elig = elig & ~revoked_q;
`endif
  end

  sla_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .elig      (elig),
    .ptr       (ptr_q),
    .onehot    (pick_oh),
    .idx       (pick_idx),
    .any_valid (pick_vld)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    win_d       = win_q;
    ptr_d       = ptr_q;
    gcnt_d      = gcnt_q;
    out_final_d = LINE_IDLE;
`ifdef SLA_TIMEOUT_EN
    hold_d      = hold_q;
    revoked_d   = revoked_q & req;
`endif
    case (state_q)
      IDLE: if (pick_vld) begin
        state_d = GRANT;
        grant_d = pick_oh;
        win_d   = pick_idx;
        ptr_d   = pick_idx;
`ifdef SLA_TIMEOUT_EN
        hold_d  = '0;
`endif
      end
      GRANT: begin
        out_final_d = tx_in[win_q];
`ifdef SLA_TIMEOUT_EN
        hold_d = hold_q + 1'b1;
`endif
        if (!req[win_q] || timeout) begin
          state_d = GUARD;
          grant_d = '0;
          gcnt_d  = '0;
`ifdef SLA_TIMEOUT_EN
          if (req[win_q]) revoked_d[win_q] = 1'b1;
`endif
        end
      end
      GUARD: begin
        if (gcnt_q == GW'(GUARD_CYCLES - 1)) state_d = IDLE;
        else                                 gcnt_d  = gcnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      win_q       <= '0;
      ptr_q       <= IW'(N_REQ - 1);
      gcnt_q      <= '0;
      out_final_q <= LINE_IDLE;
      busy_q      <= 1'b0;
`ifdef SLA_TIMEOUT_EN
      hold_q      <= '0;
      revoked_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      win_q       <= win_d;
      ptr_q       <= ptr_d;
      gcnt_q      <= gcnt_d;
      out_final_q <= out_final_d;
      busy_q      <= busy_d;
`ifdef SLA_TIMEOUT_EN
      hold_q      <= hold_d;
      revoked_q   <= revoked_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign LEDs      = grant_q;
  assign out_final = out_final_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_line_arbiter.sv
// Scoreboard bench for serial_line_arbiter: expected grants/bits are queued at stimulus time.
module tb_serial_line_arbiter;

  localparam int GUARD = 4;
`ifdef SLA_TIMEOUT_EN
  localparam int MAXH  = 8;
`else
  localparam int MAXH  = 4096;
`endif
  localparam int FRAME = (MAXH > 10) ? 10 : MAXH - 3;

  logic       sysclk, reset, lock_mode;
  logic [2:0] req, tx_in, grant, LEDs;
  logic [1:0] mode_sel;
  logic       out_final, busy;

  int n_vec = 0, n_bad = 0;
  logic [2:0] exp_g[$];
  logic       exp_bit[$];

  serial_line_arbiter #(.N_REQ(3), .GUARD_CYCLES(GUARD), .MAX_HOLD(MAXH)) dut (
    .sysclk(sysclk), .reset(reset), .req(req), .tx_in(tx_in),
    .lock_mode(lock_mode), .mode_sel(mode_sel), .grant(grant),
    .out_final(out_final), .LEDs(LEDs), .busy(busy)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_grant();
    int n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (grant == 3'b000 && n < 200);
    if (grant == 3'b000) chk("wait_grant", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge sysclk);
      n++;
    end
    if (busy !== 1'b0) chk("wait_idle", busy, 0);
  endtask

  // Grant monitor: pops the order scoreboard and measures the guard gap.
  logic [2:0] prev_g;
  int         gap;
  bit         had_prev, line_ok;
  always @(negedge sysclk) begin
    if (reset) begin
      prev_g = '0; had_prev = 0; gap = 0; line_ok = 1;
    end else begin
      if (busy && grant == 3'b000) begin
        gap++;
        if (out_final !== 1'b1) line_ok = 0;
      end
      if (grant != 3'b000 && grant != prev_g) begin
        if (exp_g.size() == 0) chk("unexp_grant", grant, 0);
        else                   chk("grant_order", grant, exp_g.pop_front());
        chk("leds", LEDs, grant);
        if (had_prev) begin
          chk("guard_gap", gap, GUARD);
          chk("guard_line", line_ok, 1);
        end
        had_prev = 1; gap = 0; line_ok = 1;
      end
      prev_g = grant;
    end
  end

  initial begin
    int b;
    reset = 1'b1; req = 3'b111; tx_in = 3'b111; lock_mode = 1'b0; mode_sel = 2'd0;

    // reset state
    repeat (2) @(negedge sysclk);
    chk("rst_grant", grant, 0);
    chk("rst_leds", LEDs, 0);
    chk("rst_line", out_final, 1);
    chk("rst_busy", busy, 0);

    // round robin, all boards requesting
    exp_g.push_back(3'b001); exp_g.push_back(3'b010);
    exp_g.push_back(3'b100); exp_g.push_back(3'b001);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_grant();
      b = 0;
      for (int i = 0; i < 3; i++) if (grant[i]) b = i;
      repeat (FRAME - 1) @(negedge sysclk);
      req[b] = 1'b0;
      @(negedge sysclk);
      req[b] = (k < 3);
    end
    req = 3'b000;
    wait_idle();

    // data path on board 1, neighbours toggling
    exp_g.push_back(3'b010);
    req = 3'b010;
    wait_grant();
    for (int k = 0; k < 4; k++) begin
      logic bit_v;
      bit_v = (k == 1 || k == 2);
      tx_in = {~k[0], bit_v, k[0]};
      exp_bit.push_back(bit_v);
      @(negedge sysclk);
      chk("data", out_final, exp_bit.pop_front());
    end
    tx_in = 3'b111;
    req = 3'b000;
    wait_idle();

    // manual mode
    lock_mode = 1'b1; mode_sel = 2'd2; req = 3'b011;
    repeat (6) @(negedge sysclk);
    chk("man_block", grant, 0);
    exp_g.push_back(3'b100);
    req = 3'b111;
    wait_grant();
    mode_sel = 2'd3;
    req = 3'b011;
    repeat (12) @(negedge sysclk);
    chk("man_none_grant", grant, 0);
    chk("man_none_busy", busy, 0);
    chk("man_queue", exp_g.size(), 0);

    // mode change mid-frame does not preempt
    exp_g.push_back(3'b001);
    lock_mode = 1'b0;
    wait_grant();
    lock_mode = 1'b1; mode_sel = 2'd1;
    repeat (4) @(negedge sysclk);
    chk("hold_on_mode", grant, 3'b001);
    exp_g.push_back(3'b010);
    req = 3'b010;
    wait_grant();
    tx_in = 3'b101;
    repeat (2) @(negedge sysclk);
    chk("grant_line", out_final, 0);
    reset = 1'b1;
    @(negedge sysclk);
    chk("midrst_grant", grant, 0);
    chk("midrst_line", out_final, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_queue", exp_g.size(), 0);
    tx_in = 3'b111;

`ifdef SLA_TIMEOUT_EN
    // hold timeout and revoke blocking
    begin
      int n;
      lock_mode = 1'b0; req = 3'b011;
      exp_g.push_back(3'b001); exp_g.push_back(3'b010);
      @(negedge sysclk);
      reset = 1'b0;
      wait_grant();
      n = 0;
      while (grant == 3'b001 && n < 50) begin
        n++;
        @(negedge sysclk);
      end
      chk("hold_len", n, MAXH);
      wait_grant();
      repeat (3) @(negedge sysclk);
      req = 3'b001;
      repeat (12) @(negedge sysclk);
      chk("revoke_block", grant, 0);
      exp_g.push_back(3'b001);
      req = 3'b000;
      @(negedge sysclk);
      req = 3'b001;
      wait_grant();
      repeat (2) @(negedge sysclk);
    end
`endif

    reset = 1'b0;
    req = 3'b000;
    repeat (8) @(negedge sysclk);
    chk("final_queue", exp_g.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
